player_motion_ctrl: RTL and testbench

Frame-paced sequencer that converts the player's forward and rotate buttons into single-cycle `forward` and `rotate` strobes for `player_register`. Each rotate step is issued immediately; each forward step is issued only after a request/acknowledge collision query to the maze lookup reports the path clear. The block sits between the board input pins and `player_register`. It also reports sticky error flags for query timeouts and frame overruns.

---
 rtl/player_motion_ctrl_pkg.sv | 16 +
 rtl/player_motion_ctrl_if.sv | 24 ++
 rtl/button_sync.sv | 30 +++
 rtl/player_motion_ctrl.sv | 176 +++++++++++++++++
 tb/tb_player_motion_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/player_motion_ctrl_pkg.sv
// Shared definitions for the player / maze blocks.
//   - PMC_* state encodings of player_motion_ctrl (legacy 2-bit codes)
//   - default rotate divider and collision-query timeout
//   - width of the forward-move counter
package player_motion_ctrl_pkg;

    localparam logic [1:0] PMC_IDLE   = 2'd0;
    localparam logic [1:0] PMC_ROTATE = 2'd1;
    localparam logic [1:0] PMC_CHECK  = 2'd2;
    localparam logic [1:0] PMC_MOVE   = 2'd3;

    localparam int unsigned PMC_ROT_DIV_DEF = 4;
    localparam int unsigned PMC_TIMEOUT_DEF = 64;
    localparam int unsigned PMC_MOVE_W      = 16;

endpackage

// File: rtl/player_motion_ctrl_if.sv
// Collision query handshake between player_motion_ctrl and the maze lookup.
//   coll_req      request, held high until acknowledged or timed out
//   coll_ack      one-cycle acknowledge
//   coll_blocked  result, valid only while coll_ack is high
// master: the requester (player_motion_ctrl); slave: the maze lookup.
interface player_motion_ctrl_if;

    logic coll_req;
    logic coll_ack;
    logic coll_blocked;

    modport master (
        output coll_req,
        input  coll_ack,
        input  coll_blocked
    );

    modport slave (
        input  coll_req,
        output coll_ack,
        output coll_blocked
    );

endinterface

// File: rtl/button_sync.sv
// Parameterised-width two-flop synchronizer for asynchronous levels.
//   clk     system clock
//   resetn  asynchronous active-low reset (outputs reset to 0)
//   d       raw asynchronous levels
//   q       levels synchronized to clk, two cycles late
module button_sync #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/player_motion_ctrl.sv
// Frame-paced sequencer turning the forward / rotate buttons into one-cycle
// strobes for player_register. Rotate steps issue at once; forward steps only
// after the maze lookup reports the path clear.
//   clk, resetn             clock, asynchronous active-low reset
//   enable                  gate for new frame ticks (only checked in IDLE)
//   frame_tick              one-cycle pulse per video frame
//   btn_forward, btn_rotate raw asynchronous button levels
//   coll                    collision query handshake (master side)
//   forward, rotate         one-cycle strobes
//   busy                    high while the sequencer is not IDLE
//   move_count              forward strobes issued, saturating
//   timeout_err             sticky: a collision query timed out
//   overrun_err             sticky: a frame tick arrived while busy
//   clear_err               synchronous clear of both sticky flags
module player_motion_ctrl
    import player_motion_ctrl_pkg::*;
#(
    parameter int unsigned ROT_DIV = PMC_ROT_DIV_DEF,
    parameter int unsigned TIMEOUT = PMC_TIMEOUT_DEF,
    parameter int unsigned MOVE_W  = PMC_MOVE_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                frame_tick,
    input  logic                btn_forward,
    input  logic                btn_rotate,
    player_motion_ctrl_if.master coll,
    output logic                forward,
    output logic                rotate,
    output logic                busy,
    output logic [MOVE_W-1:0]   move_count,
    output logic                timeout_err,
    output logic                overrun_err,
    input  logic                clear_err
);

    localparam int unsigned ROT_W  = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ROT_W-1:0]  ROT_LAST  = ROT_W'(ROT_DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [1:0] btn_s;
    logic       fwd_s;
    logic       rot_s;

    button_sync #(
        .WIDTH (2)
    ) u_button_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      ({btn_rotate, btn_forward}),
        .q      (btn_s)
    );

    assign fwd_s = btn_s[0];
    assign rot_s = btn_s[1];

    logic [1:0]        state_q, state_d;
    logic              fwd_q, fwd_d;
    logic [ROT_W-1:0]  rot_cnt_q, rot_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [MOVE_W-1:0] move_count_q, move_count_d;
    logic              timeout_err_q, timeout_err_d;
    logic              overrun_err_q, overrun_err_d;
    logic              coll_req_q, forward_q, rotate_q, busy_q;

    logic tick_acc;
    logic rot_due;
    logic timeout_set;
    logic overrun_set;

    assign tick_acc    = frame_tick && enable && (state_q == PMC_IDLE);
    // The synchronized rotate level is the value captured on this tick.
    assign rot_due     = rot_s && (rot_cnt_q == '0);
    // Ticks masked by enable only happen in IDLE, so they never land here.
    assign overrun_set = frame_tick && (state_q != PMC_IDLE);

    always_comb begin
        state_d     = state_q;
        fwd_d       = fwd_q;
        rot_cnt_d   = rot_cnt_q;
        wait_cnt_d  = '0;
        timeout_set = 1'b0;

        case (state_q)
            PMC_IDLE: begin
                if (tick_acc) begin
                    fwd_d = fwd_s;
                    if (!rot_s) begin
                        rot_cnt_d = '0;
                    end else if (rot_cnt_q == ROT_LAST) begin
                        rot_cnt_d = '0;
                    end else begin
                        rot_cnt_d = rot_cnt_q + 1'b1;
                    end
                    // Rotate first so the forward step uses the new heading.
                    if (rot_due) begin
                        state_d = PMC_ROTATE;
                    end else if (fwd_s) begin
                        state_d = PMC_CHECK;
                    end
                end
            end
            PMC_ROTATE: begin
                state_d = fwd_q ? PMC_CHECK : PMC_IDLE;
            end
            PMC_CHECK: begin
                // An ack on the final wait cycle still wins over the timeout.
                if (coll.coll_ack) begin
                    state_d = coll.coll_blocked ? PMC_IDLE : PMC_MOVE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = PMC_IDLE;
                    timeout_set = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            PMC_MOVE: begin
                state_d = PMC_IDLE;
            end
            default: begin
                state_d = PMC_IDLE;
            end
        endcase
    end

    always_comb begin
        move_count_d = move_count_q;
        if ((state_d == PMC_MOVE) && (move_count_q != {MOVE_W{1'b1}})) begin
            move_count_d = move_count_q + 1'b1;
        end
    end

    // A set on the same cycle as a clear leaves the flag set.
    assign timeout_err_d = timeout_set || (timeout_err_q && !clear_err);
    assign overrun_err_d = overrun_set || (overrun_err_q && !clear_err);

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= PMC_IDLE;
            fwd_q         <= 1'b0;
            rot_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            move_count_q  <= '0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
            coll_req_q    <= 1'b0;
            forward_q     <= 1'b0;
            rotate_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fwd_q         <= fwd_d;
            rot_cnt_q     <= rot_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            move_count_q  <= move_count_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
            coll_req_q    <= (state_d == PMC_CHECK);
            forward_q     <= (state_d == PMC_MOVE);
            rotate_q      <= (state_d == PMC_ROTATE);
            busy_q        <= (state_d != PMC_IDLE);
        end
    end

    assign coll.coll_req = coll_req_q;
    assign forward       = forward_q;
    assign rotate        = rotate_q;
    assign busy          = busy_q;
    assign move_count    = move_count_q;
    assign timeout_err   = timeout_err_q;
    assign overrun_err   = overrun_err_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl. Main instance uses the default
// parameters; a second instance with a 2-bit move counter and an
// auto-acknowledging lookup covers counter saturation.
module tb_player_motion_ctrl;

    logic clk;
    logic resetn;
    logic enable;
    logic frame_tick;
    logic btn_forward;
    logic btn_rotate;
    logic clear_err;
    logic forward;
    logic rotate;
    logic busy;
    logic [15:0] move_count;
    logic timeout_err;
    logic overrun_err;

    player_motion_ctrl_if coll_if ();

    player_motion_ctrl u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .frame_tick  (frame_tick),
        .btn_forward (btn_forward),
        .btn_rotate  (btn_rotate),
        .coll        (coll_if),
        .forward     (forward),
        .rotate      (rotate),
        .busy        (busy),
        .move_count  (move_count),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err),
        .clear_err   (clear_err)
    );

    // Saturation instance
    logic       s_tick;
    logic       s_fwd;
    logic       s_forward;
    logic       s_rotate;
    logic       s_busy;
    logic [1:0] s_count;
    logic       s_terr;
    logic       s_oerr;

    player_motion_ctrl_if sat_if ();
    assign sat_if.coll_ack     = sat_if.coll_req;
    assign sat_if.coll_blocked = 1'b0;

    player_motion_ctrl #(
        .MOVE_W (2)
    ) u_sat (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (1'b1),
        .frame_tick  (s_tick),
        .btn_forward (s_fwd),
        .btn_rotate  (1'b0),
        .coll        (sat_if),
        .forward     (s_forward),
        .rotate      (s_rotate),
        .busy        (s_busy),
        .move_count  (s_count),
        .timeout_err (s_terr),
        .overrun_err (s_oerr),
        .clear_err   (1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse frame_tick for one cycle; returns at cycle 1 after the tick.
    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    // Called at cycle c; acks during cycle c+k-1, returns at cycle c+k.
    task automatic ack_at(input int k, input logic blk);
        repeat (k - 1) @(negedge clk);
        coll_if.coll_ack     = 1'b1;
        coll_if.coll_blocked = blk;
        @(negedge clk);
        coll_if.coll_ack     = 1'b0;
        coll_if.coll_blocked = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        resetn = 1'b0;
        enable = 1'b1;
        frame_tick = 1'b0;
        btn_forward = 1'b0;
        btn_rotate = 1'b0;
        clear_err = 1'b0;
        coll_if.coll_ack = 1'b0;
        coll_if.coll_blocked = 1'b0;
        s_tick = 1'b0;
        s_fwd = 1'b0;
        cyc(2);

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_req", coll_if.coll_req, 0);
        chk("rst_fwd", forward, 0);
        chk("rst_rot", rotate, 0);
        chk("rst_cnt", move_count, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_oerr", overrun_err, 0);
        resetn = 1'b1;
        cyc(2);

        // Forward held, ack on the 3rd CHECK cycle, two frames
        btn_forward = 1'b1;
        cyc(3);
        for (int f = 1; f <= 2; f++) begin
            tick();
            chk("fw_req_c1", coll_if.coll_req, 1);
            chk("fw_busy_c1", busy, 1);
            chk("fw_rot_c1", rotate, 0);
            ack_at(3, 1'b0);
            chk("fw_strobe", forward, 1);
            chk("fw_count", move_count, f);
            chk("fw_req_off", coll_if.coll_req, 0);
            cyc(1);
            chk("fw_strobe_off", forward, 0);
            chk("fw_idle", busy, 0);
        end

        // Blocked path: no move
        tick();
        ack_at(1, 1'b1);
        chk("blk_fwd", forward, 0);
        chk("blk_idle", busy, 0);
        chk("blk_cnt", move_count, 2);

        // Ack outside CHECK is ignored
        coll_if.coll_ack = 1'b1;
        cyc(1);
        coll_if.coll_ack = 1'b0;
        cyc(1);
        chk("stray_ack_busy", busy, 0);
        chk("stray_ack_fwd", forward, 0);

        // Ticks with enable low are ignored and are not overruns
        enable = 1'b0;
        tick();
        chk("dis_busy", busy, 0);
        cyc(1);
        chk("dis_oerr", overrun_err, 0);
        enable = 1'b1;

        // Rotate held 9 frames with ROT_DIV=4: pulses on frames 1, 5, 9
        btn_forward = 1'b0;
        btn_rotate = 1'b1;
        cyc(3);
        for (int f = 1; f <= 9; f++) begin
            tick();
            chk("rot_pulse", rotate, (f == 1 || f == 5 || f == 9) ? 1 : 0);
            chk("rot_noreq", coll_if.coll_req, 0);
            cyc(1);
            chk("rot_pulse_off", rotate, 0);
        end

        // Release then press again: immediate pulse
        btn_rotate = 1'b0;
        cyc(3);
        tick();
        chk("rel_rot", rotate, 0);
        btn_rotate = 1'b1;
        cyc(3);
        tick();
        chk("repress_rot", rotate, 1);
        cyc(1);

        // Both held: rotate at c1, req at c2, forward after ack
        btn_rotate = 1'b0;
        cyc(3);
        tick();
        btn_forward = 1'b1;
        btn_rotate = 1'b1;
        cyc(3);
        tick();
        chk("both_rot_c1", rotate, 1);
        chk("both_req_c1", coll_if.coll_req, 0);
        chk("both_fwd_c1", forward, 0);
        cyc(1);
        chk("both_rot_c2", rotate, 0);
        chk("both_req_c2", coll_if.coll_req, 1);
        ack_at(1, 1'b0);
        chk("both_fwd", forward, 1);
        chk("both_rot_fwd", rotate, 0);
        chk("both_cnt", move_count, 3);
        cyc(1);
        chk("both_idle", busy, 0);

        // Overrun during CHECK, with a simultaneous clear (set wins)
        tick();
        chk("ovr_rot", rotate, 0);
        chk("ovr_req", coll_if.coll_req, 1);
        frame_tick = 1'b1;
        clear_err = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        clear_err = 1'b0;
        chk("ovr_flag", overrun_err, 1);
        chk("ovr_busy", busy, 1);
        chk("ovr_rot2", rotate, 0);
        ack_at(1, 1'b0);
        chk("ovr_fwd", forward, 1);
        chk("ovr_cnt", move_count, 4);
        cyc(1);
        chk("ovr_idle", busy, 0);
        chk("ovr_no_extra", rotate, 0);
        cyc(1);
        chk("ovr_cnt_stable", move_count, 4);
        clear_err = 1'b1;
        cyc(1);
        clear_err = 1'b0;
        chk("ovr_clear", overrun_err, 0);

        // Timeout: coll_req high exactly 64 cycles
        btn_rotate = 1'b0;
        cyc(3);
        tick();
        n = 0;
        while (coll_if.coll_req === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("to_req_cycles", n, 64);
        chk("to_flag", timeout_err, 1);
        chk("to_fwd", forward, 0);
        chk("to_idle", busy, 0);
        chk("to_cnt", move_count, 4);
        clear_err = 1'b1;
        cyc(1);
        clear_err = 1'b0;
        chk("to_clear", timeout_err, 0);

        // Reset mid-CHECK drops coll_req and busy asynchronously
        tick();
        chk("mr_req", coll_if.coll_req, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("mr_req_async", coll_if.coll_req, 0);
        chk("mr_busy_async", busy, 0);
        @(negedge clk);
        chk("mr_cnt", move_count, 0);
        chk("mr_fwd", forward, 0);
        resetn = 1'b1;
        btn_rotate = 1'b1;
        cyc(3);
        tick();
        chk("mr_first_rot", rotate, 1);
        cyc(1);
        chk("mr_first_req", coll_if.coll_req, 1);
        ack_at(1, 1'b0);
        chk("mr_first_fwd", forward, 1);
        chk("mr_first_cnt", move_count, 1);
        btn_forward = 1'b0;
        btn_rotate = 1'b0;

        // Saturation on the 2-bit instance
        s_fwd = 1'b1;
        cyc(3);
        for (int i = 1; i <= 5; i++) begin
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
            cyc(2);
            chk("sat_cnt", s_count, (i < 3) ? i : 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
